// File: rtl/ring3_pkg.sv
// Shared definitions for the three-state step counter and its driver.
package ring3_pkg;

  localparam logic [1:0] R3_IDLE = 2'b00;
  localparam logic [1:0] R3_S0   = 2'b01;
  localparam logic [1:0] R3_S1   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_WAIT = 2'd2
  } r3_state_e;

  // Successor of a counter code; the illegal code 11 falls back to 00.
  function automatic logic [1:0] r3_next(input logic [1:0] code);
    case (code)
      R3_IDLE: r3_next = R3_S0;
      R3_S0:   r3_next = R3_S1;
      default: r3_next = R3_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ring3_gap_timer.sv
// Loadable 8-bit down-counter timing the idle gap between step pulses.
// expire is high whenever the count has reached zero.
module ring3_gap_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       expire
);

  logic [7:0] cnt;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst)             cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != 8'd0) cnt <= cnt - 8'd1;
  end

  assign expire = (cnt == 8'd0);

endmodule

// File: rtl/ring3_step_driver.sv
// Step driver for the three-state ring counter: accepts a target code,
// emits 1 or 2 step pulses (GAP idle cycles apart) and mirrors the counter.
// Optional feedback check: define RING3_FB_CHECK_EN to compare fb_code
// against the mirror every cycle and resynchronise on a mismatch.
module ring3_step_driver
  import ring3_pkg::*;
#(
  parameter int GAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_code,
  output logic       step,
  input  logic [1:0] fb_code,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] mirror
);

  r3_state_e  state, state_n;
  logic [1:0] target, target_n, mirror_n;
  logic       done_n, err_n, tmr_load, gap_expire, accept, fb_mis;
  logic [1:0] fb_fix;

  assign step      = (state == ST_STEP);
  assign busy      = (state != ST_IDLE);
  assign req_ready = (state == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

`ifdef RING3_FB_CHECK_EN
  assign fb_mis = (fb_code != mirror);
  assign fb_fix = (fb_code == 2'b11) ? R3_IDLE : fb_code;
`else
  // Mirror is purely predictive; feedback is not observed.
  logic unused_fb;
  assign fb_mis    = 1'b0;
  assign fb_fix    = mirror;
  assign unused_fb = ^fb_code;
`endif

  // The gap timer only exists when there is a gap to time.
  generate
    if (GAP > 0) begin : g_gap
      ring3_gap_timer u_gap (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (8'(GAP - 1)),
        .expire   (gap_expire)
      );
    end else begin : g_nogap
      logic unused_tmr;
      assign unused_tmr = tmr_load;
      assign gap_expire = 1'b1;
    end
  endgenerate

  // State, mirror, target and registered done/err pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      mirror <= R3_IDLE;
      target <= R3_IDLE;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      mirror <= mirror_n;
      target <= target_n;
      done   <= done_n;
      err    <= err_n;
    end
  end

  // Next-state logic; a feedback mismatch overrides everything else.
  always_comb begin
    state_n  = state;
    mirror_n = mirror;
    target_n = target;
    done_n   = 1'b0;
    err_n    = 1'b0;
    tmr_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_code == 2'b11)       err_n = 1'b1;
          else if (req_code == mirror) done_n = 1'b1;
          else begin
            target_n = req_code;
            state_n  = ST_STEP;
          end
        end
      end
      ST_STEP: begin
        mirror_n = r3_next(mirror);
        if (mirror_n == target) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else if (GAP > 0) begin
          state_n  = ST_WAIT;
          tmr_load = 1'b1;
        end
      end
      ST_WAIT: begin
        if (gap_expire) state_n = ST_STEP;
      end
      default: state_n = ST_IDLE;
    endcase
    if (fb_mis) begin
      mirror_n = fb_fix;
      state_n  = ST_IDLE;
      done_n   = 1'b0;
      err_n    = 1'b1;
      tmr_load = 1'b0;
    end
  end

endmodule

// File: tb/tb_ring3_step_driver.sv
// Bench for ring3_step_driver: two instances (GAP=0 and GAP=3), each with a
// counter model on its step output. Expected timing is derived from the step
// count (target - mirror) mod 3 and the gap length.
module tb_ring3_step_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       rv[2], rdy[2], st[2], bz[2], dn[2], er[2];
  logic [1:0] rc[2], fb[2], mir[2], cnt[2];
  logic       fen[2], ld[2];
  logic [1:0] fv, ldv;
  int         mdl[2];
  int         vec = 0, miss = 0;

  always #5 clk = ~clk;

  ring3_step_driver #(.GAP(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .req_code(rc[0]),
    .step(st[0]), .fb_code(fb[0]), .busy(bz[0]), .done(dn[0]), .err(er[0]), .mirror(mir[0]));

  ring3_step_driver #(.GAP(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .req_code(rc[1]),
    .step(st[1]), .fb_code(fb[1]), .busy(bz[1]), .done(dn[1]), .err(er[1]), .mirror(mir[1]));

  // Counter models: reset to 00, advance once per step, optional forced load.
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (rst)        cnt[i] <= 2'd0;
      else if (ld[i]) cnt[i] <= ldv;
      else if (st[i]) cnt[i] <= (cnt[i] == 2'd2) ? 2'd0 : cnt[i] + 2'd1;

  assign fb[0] = fen[0] ? fv : cnt[0];
  assign fb[1] = fen[1] ? fv : cnt[1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input int d);
    chk("rst_ready", rdy[d], 0);
    chk("rst_step", st[d], 0);
    chk("rst_busy", bz[d], 0);
    chk("rst_done", dn[d], 0);
    chk("rst_err", er[d], 0);
    chk("rst_mirror", mir[d], 0);
  endtask

  // One request on instance d. pre: accept edge already happened (valid held
  // from a previous hold transfer). hold: keep valid high with a changing code
  // and present nxt in the done cycle so it is accepted at the following edge.
  task automatic do_req(input int d, input logic [1:0] code, input bit pre,
                        input bit hold, input logic [1:0] nxt);
    int m, g, steps, s1, s2, dc, len, nb;
    bit ill;
    m     = mdl[d];
    g     = (d == 0) ? 0 : 3;
    ill   = (code == 2'd3);
    steps = ill ? 0 : (int'(code) - m + 3) % 3;
    s1    = (steps >= 1) ? 1 : -1;
    s2    = (steps == 2) ? 2 + g : -1;
    dc    = ill ? -1 : (steps == 0 ? 1 : (steps == 1 ? 2 : 3 + g));
    len   = ill ? 1 : dc;
    if (!pre) begin
      @(negedge clk);
      chk("ready_pre", rdy[d], 1);
      rv[d] = 1'b1; rc[d] = code;
      @(posedge clk); #1;
    end
    if (!hold) rv[d] = 1'b0;
    for (int k = 1; k <= len; k++) begin
      if (hold) rc[d] = (k == len) ? nxt : 2'($urandom_range(0, 3));
      @(negedge clk);
      nb = ((s1 > 0 && s1 < k) ? 1 : 0) + ((s2 > 0 && s2 < k) ? 1 : 0);
      chk("step", st[d], (k == s1) || (k == s2));
      chk("done", dn[d], k == dc);
      chk("err", er[d], ill && k == 1);
      chk("busy", bz[d], !ill && steps > 0 && k < dc);
      chk("ready", rdy[d], !(!ill && steps > 0 && k < dc));
      chk("mirror", mir[d], (m + nb) % 3);
      chk("fb_eq_mirror", cnt[d], mir[d]);
      @(posedge clk); #1;
    end
    if (!ill) mdl[d] = int'(code);
  endtask

  initial begin
    int d, t;
    rst = 1'b1; fv = 2'd0; ldv = 2'd0;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rc[i] = 2'd0; fen[i] = 1'b0; ld[i] = 1'b0; mdl[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst(0); chk_rst(1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst0", rdy[0], 1);
    chk("ready_after_rst1", rdy[1], 1);
    @(posedge clk); #1;

    // GAP=0, 00 -> 10: steps in cycles 1-2, done in 3.
    do_req(0, 2'd2, 0, 0, 0);
    // GAP=3: reach 10, then single step to 00, then 00 -> 10 (steps 1 and 5).
    do_req(1, 2'd2, 0, 0, 0);
    do_req(1, 2'd0, 0, 0, 0);
    do_req(1, 2'd2, 0, 0, 0);

    // Back-to-back: zero-step request followed immediately by an illegal one.
    do_req(0, 2'd1, 0, 0, 0);
    @(negedge clk);
    rv[0] = 1'b1; rc[0] = 2'd1;
    @(posedge clk); #1 rc[0] = 2'd3;
    @(negedge clk);
    chk("b2b_done1", dn[0], 1);
    chk("b2b_err1", er[0], 0);
    chk("b2b_step1", st[0], 0);
    chk("b2b_ready1", rdy[0], 1);
    @(posedge clk); #1 rv[0] = 1'b0;
    @(negedge clk);
    chk("b2b_done2", dn[0], 0);
    chk("b2b_err2", er[0], 1);
    chk("b2b_step2", st[0], 0);
    chk("b2b_mirror", mir[0], 1);
    @(posedge clk); #1;

    // Valid held through a 2-step transfer with a wandering code.
    do_req(1, 2'd1, 0, 1, 2'd0);
    do_req(1, 2'd0, 1, 0, 0);

`ifdef RING3_FB_CHECK_EN
    // Feedback forced to 10 during the first step of 00 -> 10.
    @(negedge clk);
    rv[1] = 1'b1; rc[1] = 2'd2;
    @(posedge clk); #1;
    rv[1] = 1'b0; fen[1] = 1'b1; fv = 2'd2; ld[1] = 1'b1; ldv = 2'd2;
    @(negedge clk);
    chk("fb_step", st[1], 1);
    @(posedge clk); #1 fen[1] = 1'b0; ld[1] = 1'b0;
    @(negedge clk);
    chk("fb_err", er[1], 1);
    chk("fb_done", dn[1], 0);
    chk("fb_mirror", mir[1], 2);
    chk("fb_busy", bz[1], 0);
    chk("fb_ready", rdy[1], 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fb_err_clear", er[1], 0);
    chk("fb_done_none", dn[1], 0);
    @(posedge clk); #1;
    mdl[1] = 2;
`else
    // Feedback disagreement is ignored when the check is compiled out.
    fen[0] = 1'b1; fv = 2'd3;
    @(posedge clk); #1 fen[0] = 1'b0;
    @(negedge clk);
    chk("nofb_err", er[0], 0);
    chk("nofb_mirror", mir[0], mdl[0]);
    @(posedge clk); #1;
`endif

    // Reset while the GAP=3 instance waits between its two steps.
    t = (mdl[1] + 2) % 3;
    @(negedge clk);
    rv[1] = 1'b1; rc[1] = 2'(t);
    @(posedge clk); #1 rv[1] = 1'b0;
    @(negedge clk);
    chk("mid_step", st[1], 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_wait_busy", bz[1], 1);
    chk("mid_wait_step", st[1], 0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_rst(1);
    rst = 1'b0;
    mdl[0] = 0; mdl[1] = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_done", dn[1], 0);
    chk("post_rst_err", er[1], 0);
    chk("post_rst_ready", rdy[1], 1);
    chk("post_rst_busy", bz[1], 0);
    @(posedge clk); #1;
    do_req(1, 2'd2, 0, 0, 0);

    // Randomized requests on either instance, including illegal codes.
    for (int n = 0; n < 40; n++) begin
      d = int'($urandom_range(0, 1));
      do_req(d, 2'($urandom_range(0, 3)), 0, 0, 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
